// File: rtl/ft_breakage_monitor_bank.sv
// Leaky-bucket breakage monitor for the triplicated IF-stage voters, with a round-robin report handshake.
// Optional macro FT_BRKMON_RECOVER_EN: a slot's broken flag drops again once its counter decays to 0.
module ft_breakage_monitor_bank #(
    parameter int                     N_MOD              = 6,
    parameter int                     COUNT_BIT          = 8,
    parameter int                     INC_DEC_BIT        = 2,
    parameter logic [INC_DEC_BIT-1:0] INCREMENT          = 2'd1,
    parameter logic [INC_DEC_BIT-1:0] DECREMENT          = 2'd1,
    parameter int                     BREAKING_THRESHOLD = 3,
    localparam int                    IDXW               = (N_MOD > 1) ? $clog2(N_MOD) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_MOD-1:0]     err_i,
    input  logic [N_MOD-1:0]     chk_i,
    input  logic                 clear_i,
    output logic [N_MOD-1:0]     broken_o,
    output logic                 any_broken_o,
    output logic                 report_valid_o,
    input  logic                 report_ready_i,
    output logic [IDXW-1:0]      report_idx_o,
    output logic [COUNT_BIT-1:0] report_count_o
);

    localparam logic [COUNT_BIT-1:0] CNT_MAX  = {COUNT_BIT{1'b1}};
    localparam logic [COUNT_BIT-1:0] CNT_ZERO = {COUNT_BIT{1'b0}};
    localparam logic [COUNT_BIT-1:0] CNT_TH   = COUNT_BIT'(BREAKING_THRESHOLD);
    localparam logic [COUNT_BIT:0]   INC_EXT  = (COUNT_BIT+1)'(INCREMENT);
    localparam logic [COUNT_BIT-1:0] DEC_EXT  = COUNT_BIT'(DECREMENT);
    localparam logic [IDXW-1:0]      IDX_ZERO = {IDXW{1'b0}};
    localparam logic [IDXW-1:0]      IDX_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0]      IDX_LAST = IDXW'(N_MOD - 1);
    localparam logic [IDXW:0]        POS_N    = (IDXW+1)'(N_MOD);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PRESENT = 1'b1} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [COUNT_BIT-1:0]   r_cnt [N_MOD];
    logic [COUNT_BIT-1:0]   w_cnt_nxt [N_MOD];
    logic [COUNT_BIT:0]     w_sum [N_MOD];
    logic [IDXW:0]          w_pos [N_MOD];
    logic [N_MOD-1:0]       r_broken;
    logic [N_MOD-1:0]       w_broken_nxt;
    logic [N_MOD-1:0]       r_pending;
    logic [N_MOD-1:0]       w_take_mask;
    logic                   r_any;
    logic [IDXW-1:0]        r_rr;
    logic [IDXW-1:0]        r_idx;
    logic [COUNT_BIT-1:0]   r_count;
    logic                   w_found;
    logic [IDXW-1:0]        w_sel;
    logic                   w_load;
    logic                   w_accept;

    // Per-slot counter step (mismatch beats clean compare) and broken-flag update.
    always_comb begin
        for (int i = 0; i < N_MOD; i++) begin
            w_sum[i] = {1'b0, r_cnt[i]} + INC_EXT;
            if (err_i[i]) begin
                w_cnt_nxt[i] = w_sum[i][COUNT_BIT] ? CNT_MAX : w_sum[i][COUNT_BIT-1:0];
            end else if (chk_i[i]) begin
                w_cnt_nxt[i] = (r_cnt[i] >= DEC_EXT) ? (r_cnt[i] - DEC_EXT) : CNT_ZERO;
            end else begin
                w_cnt_nxt[i] = r_cnt[i];
            end
`ifdef FT_BRKMON_RECOVER_EN
            if (w_cnt_nxt[i] == CNT_ZERO) begin
                w_broken_nxt[i] = 1'b0;
            end else begin
                w_broken_nxt[i] = r_broken[i] | (w_cnt_nxt[i] >= CNT_TH);
            end
`else
            w_broken_nxt[i] = r_broken[i] | (w_cnt_nxt[i] >= CNT_TH);
`endif
        end
    end

    // Round-robin search: descending scan so the slot closest to the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = IDX_ZERO;
        for (int k = N_MOD - 1; k >= 0; k--) begin
            w_pos[k] = {1'b0, r_rr} + (IDXW+1)'(k);
            w_pos[k] = (w_pos[k] >= POS_N) ? (w_pos[k] - POS_N) : w_pos[k];
            w_found  = w_found | r_pending[w_pos[k][IDXW-1:0]];
            w_sel    = r_pending[w_pos[k][IDXW-1:0]] ? w_pos[k][IDXW-1:0] : w_sel;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; clear_i aborts any report in flight.
    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_nxt = w_found ? ST_PRESENT : ST_IDLE;
                ST_PRESENT: w_state_nxt = report_ready_i ? ST_IDLE : ST_PRESENT;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM output decode: load a report from IDLE, accept it in PRESENT.
    always_comb begin
        w_load      = 1'b0;
        w_accept    = 1'b0;
        w_take_mask = {N_MOD{1'b0}};
        case (r_state)
            ST_IDLE: begin
                w_load = w_found;
                if (w_found) begin
                    w_take_mask[w_sel] = 1'b1;
                end else begin
                    w_take_mask = {N_MOD{1'b0}};
                end
            end
            ST_PRESENT: w_accept = report_ready_i;
            default:    w_accept = 1'b0;
        endcase
    end

    // Counters, flags, pending set and report registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_MOD; i++) r_cnt[i] <= CNT_ZERO;
            r_broken  <= {N_MOD{1'b0}};
            r_pending <= {N_MOD{1'b0}};
            r_any     <= 1'b0;
            r_rr      <= IDX_ZERO;
            r_idx     <= IDX_ZERO;
            r_count   <= CNT_ZERO;
        end else if (clear_i) begin
            for (int i = 0; i < N_MOD; i++) r_cnt[i] <= CNT_ZERO;
            r_broken  <= {N_MOD{1'b0}};
            r_pending <= {N_MOD{1'b0}};
            r_any     <= 1'b0;
            r_rr      <= IDX_ZERO;
            r_idx     <= IDX_ZERO;
            r_count   <= CNT_ZERO;
        end else begin
            for (int i = 0; i < N_MOD; i++) r_cnt[i] <= w_cnt_nxt[i];
            r_broken  <= w_broken_nxt;
            r_any     <= |w_broken_nxt;
            r_pending <= (r_pending & ~w_take_mask) | (w_broken_nxt & ~r_broken);
            if (w_load) begin
                r_idx   <= w_sel;
                r_count <= r_cnt[w_sel];
            end else begin
                r_idx   <= r_idx;
                r_count <= r_count;
            end
            if (w_accept) begin
                r_rr <= (r_idx == IDX_LAST) ? IDX_ZERO : (r_idx + IDX_ONE);
            end else begin
                r_rr <= r_rr;
            end
        end
    end

    assign broken_o       = r_broken;
    assign any_broken_o   = r_any;
    assign report_valid_o = (r_state == ST_PRESENT);
    assign report_idx_o   = r_idx;
    assign report_count_o = r_count;

endmodule

// File: tb/tb_ft_breakage_monitor_bank.sv
// Randomized and directed bench for ft_breakage_monitor_bank against a slot-level behavioural model.
module tb_ft_breakage_monitor_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] err_i = 6'd0;
    logic [5:0] chk_i = 6'd0;
    logic       clear_i = 1'b0;
    logic       report_ready_i = 1'b0;
    logic [5:0] broken_o;
    logic       any_broken_o;
    logic       report_valid_o;
    logic [2:0] report_idx_o;
    logic [7:0] report_count_o;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    int m_cnt [6];
    bit m_brk [6];
    bit m_pend [6];
    bit m_present;
    int m_idx, m_count, m_rr;

    ft_breakage_monitor_bank dut (
        .clk(clk), .rst_n(rst_n), .err_i(err_i), .chk_i(chk_i), .clear_i(clear_i),
        .broken_o(broken_o), .any_broken_o(any_broken_o), .report_valid_o(report_valid_o),
        .report_ready_i(report_ready_i), .report_idx_o(report_idx_o), .report_count_o(report_count_o)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        for (int i = 0; i < 6; i++) begin
            m_cnt[i] = 0; m_brk[i] = 0; m_pend[i] = 0;
        end
        m_present = 0; m_idx = 0; m_count = 0; m_rr = 0;
    endtask

    task automatic m_update(input logic [5:0] e, input logic [5:0] c, input logic clr, input logic rdy);
        bit nb;
        if (clr) begin
            m_reset();
            return;
        end
        // Reporting decisions use the pre-edge state.
        if (m_present) begin
            if (rdy) begin
                m_rr = (m_idx + 1) % 6;
                m_present = 0;
            end
        end else begin
            for (int k = 0; k < 6; k++) begin
                int j;
                j = (m_rr + k) % 6;
                if (!m_present && m_pend[j]) begin
                    m_present = 1; m_idx = j; m_count = m_cnt[j]; m_pend[j] = 0;
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (e[i]) m_cnt[i] = (m_cnt[i] + 1 > 255) ? 255 : m_cnt[i] + 1;
            else if (c[i]) m_cnt[i] = (m_cnt[i] >= 1) ? m_cnt[i] - 1 : 0;
`ifdef FT_BRKMON_RECOVER_EN
            nb = (m_cnt[i] == 0) ? 1'b0 : (m_brk[i] || m_cnt[i] >= 3);
`else
            nb = m_brk[i] || m_cnt[i] >= 3;
`endif
            if (nb && !m_brk[i]) m_pend[i] = 1;
            m_brk[i] = nb;
        end
    endtask

    function automatic logic [18:0] exp_vec();
        logic [5:0] b;
        for (int i = 0; i < 6; i++) b[i] = m_brk[i];
        return {b, |b, m_present, 3'(m_idx), 8'(m_count)};
    endfunction

    function automatic logic [18:0] obs_vec();
        return {broken_o, any_broken_o, report_valid_o, report_idx_o, report_count_o};
    endfunction

    task automatic step(input logic [5:0] e, input logic [5:0] c, input logic clr, input logic rdy);
        err_i = e; chk_i = c; clear_i = clr; report_ready_i = rdy;
        @(posedge clk);
        m_update(e, c, clr, rdy);
        #1;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (obs_vec() !== 19'd0) begin
            miscompares++;
            $display("FAIL reset: got %h expected %h", obs_vec(), 19'd0);
        end
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic test_single_break();
        for (int t = 0; t < 3; t++) step(6'b000100, 6'd0, 1'b0, 1'b0);
        vectors++;
        if (broken_o !== 6'b000100) begin
            miscompares++;
            $display("FAIL single_broken: got %b expected %b", broken_o, 6'b000100);
        end
        step(6'd0, 6'd0, 1'b0, 1'b0);
        vectors++;
        if ({report_valid_o, report_idx_o, report_count_o} !== {1'b1, 3'd2, 8'd3}) begin
            miscompares++;
            $display("FAIL single_report: got %b/%0d/%0d expected 1/2/3", report_valid_o, report_idx_o, report_count_o);
        end
        for (int t = 0; t < 5; t++) begin
            step(6'd0, 6'd0, 1'b0, 1'b0);
            vectors++;
            if (obs_vec() !== exp_vec() || report_valid_o !== 1'b1) begin
                miscompares++;
                $display("FAIL single_hold: got %h expected %h", obs_vec(), exp_vec());
            end
        end
        step(6'd0, 6'd0, 1'b0, 1'b1);
        vectors++;
        if (report_valid_o !== 1'b0 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL single_accept: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_toggle();
        step(6'd0, 6'd0, 1'b1, 1'b0);
        for (int t = 0; t < 20; t++) begin
            if (t % 2 == 0) step(6'b000001, 6'd0, 1'b0, 1'b1);
            else step(6'd0, 6'b000001, 1'b0, 1'b1);
            vectors++;
            if (broken_o !== 6'd0 || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL toggle: cycle %0d got %h expected %h", t, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_saturate();
        step(6'd0, 6'd0, 1'b1, 1'b0);
        for (int t = 0; t < 4; t++) step((t < 3) ? 6'b000001 : 6'd0, 6'd0, 1'b0, 1'b0);
        for (int t = 0; t < 300; t++) begin
            step(6'b100000, 6'd0, 1'b0, 1'b0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL saturate_run: cycle %0d got %h expected %h", t, obs_vec(), exp_vec());
            end
        end
        step(6'd0, 6'd0, 1'b0, 1'b1);
        step(6'd0, 6'd0, 1'b0, 1'b0);
        vectors++;
        if ({report_valid_o, report_idx_o, report_count_o} !== {1'b1, 3'd5, 8'd255}) begin
            miscompares++;
            $display("FAIL saturate_count: got %b/%0d/%0d expected 1/5/255", report_valid_o, report_idx_o, report_count_o);
        end
        step(6'd0, 6'd0, 1'b0, 1'b1);
    endtask

    task automatic test_round_robin();
        int got[$];
        int exp_order[4] = '{1, 4, 5, 0};
        bit prev_valid = 0;
        step(6'd0, 6'd0, 1'b1, 1'b1);
        for (int t = 0; t < 20; t++) begin
            logic [5:0] e;
            e = (t < 3) ? 6'b110010 : ((t >= 11 && t < 14) ? 6'b000001 : 6'd0);
            step(e, 6'd0, 1'b0, 1'b1);
            vectors++;
            if (obs_vec() !== exp_vec() || (prev_valid && report_valid_o)) begin
                miscompares++;
                $display("FAIL rr_cycle: cycle %0d got %h expected %h", t, obs_vec(), exp_vec());
            end
            if (report_valid_o === 1'b1) got.push_back(int'(report_idx_o));
            prev_valid = report_valid_o;
        end
        vectors++;
        if (got.size() != 4) begin
            miscompares++;
            $display("FAIL rr_count: got %0d reports expected 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (got[k] != exp_order[k]) begin
                    miscompares++;
                    $display("FAIL rr_order: report %0d got idx %0d expected %0d", k, got[k], exp_order[k]);
                end
            end
        end
    endtask

    task automatic test_clear();
        step(6'd0, 6'd0, 1'b1, 1'b0);
        for (int t = 0; t < 4; t++) step((t < 3) ? 6'b001000 : 6'd0, 6'd0, 1'b0, 1'b0);
        vectors++;
        if ({report_valid_o, report_idx_o} !== {1'b1, 3'd3}) begin
            miscompares++;
            $display("FAIL clear_pre: got %b/%0d expected 1/3", report_valid_o, report_idx_o);
        end
        step(6'b001000, 6'd0, 1'b1, 1'b0);
        vectors++;
        if (obs_vec() !== 19'd0) begin
            miscompares++;
            $display("FAIL clear_now: got %h expected %h", obs_vec(), 19'd0);
        end
        for (int t = 0; t < 3; t++) begin
            step(6'b001000, 6'd0, 1'b0, 1'b0);
            vectors++;
            if (broken_o[3] !== ((t == 2) ? 1'b1 : 1'b0) || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL clear_after: cycle %0d got %h expected %h", t, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        step(6'd0, 6'd0, 1'b1, 1'b0);
        for (int t = 0; t < 4; t++) step((t < 3) ? 6'b000010 : 6'd0, 6'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs_vec() !== 19'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h", obs_vec(), 19'd0);
        end
        m_reset();
        #2 rst_n = 1'b1;
        step(6'd0, 6'd0, 1'b0, 1'b0);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL async_release: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_recover();
        logic want;
        step(6'd0, 6'd0, 1'b1, 1'b1);
        for (int t = 0; t < 3; t++) step(6'b000100, 6'd0, 1'b0, 1'b1);
        for (int t = 0; t < 3; t++) step(6'd0, 6'b000100, 1'b0, 1'b1);
`ifdef FT_BRKMON_RECOVER_EN
        want = 1'b0;
`else
        want = 1'b1;
`endif
        vectors++;
        if (broken_o[2] !== want || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL recover: broken %b expected bit2=%b, got %h expected %h", broken_o, want, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 1500; t++) begin
            logic [5:0] e, c;
            for (int i = 0; i < 6; i++) begin
                e[i] = ($urandom_range(0, 3) == 0);
                c[i] = $urandom_range(0, 1) == 1;
            end
            step(e, c, $urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random: cycle %0d got %h expected %h", t, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_break();
        test_toggle();
        test_saturate();
        test_round_robin();
        test_clear();
        test_async_reset();
        test_recover();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ft_breakage_monitor_bank.md
Name: ft_breakage_monitor_bank

Overview:
- Consumer side of the fault-tolerant voter error outputs for the IF-stage submodules.
- Each triplicated submodule's voter reports a per-cycle mismatch strobe on the slot given by its IFST_*_I index (0..5).
- Keeps one saturating leaky-bucket counter per slot and declares a slot broken when its counter reaches threshold.
- Reports newly broken slots one at a time to the controller over a valid/ready handshake.

Parameters:
- N_MOD, 6, number of monitored submodule slots (slot i = IFST_*_I index i).
- COUNT_BIT, 8, width of each counter.
- INC_DEC_BIT, 2, width of the INCREMENT/DECREMENT step values.
- INCREMENT, 1, counter step added on a mismatch cycle.
- DECREMENT, 1, counter step subtracted on a clean compare cycle.
- BREAKING_THRESHOLD, 3, counter value at or above which a slot is broken.

Ports:
- clk, in, 1, core clock.
- rst_n, in, 1, asynchronous active-low reset.
- err_i, in, N_MOD, voter mismatch strobe per slot, sampled each clk.
- chk_i, in, N_MOD, voter performed a comparison this cycle.
- clear_i, in, 1, synchronous clear of all counters, broken flags and pending reports.
- broken_o, out, N_MOD, registered broken flag per slot.
- any_broken_o, out, 1, OR of broken_o.
- report_valid_o, out, 1, a broken-slot report is presented.
- report_ready_i, in, 1, controller accepts the report.
- report_idx_o, out, $clog2(N_MOD), slot index of the presented report.
- report_count_o, out, COUNT_BIT, counter value of that slot, captured when the report was loaded.

Behaviour:
- Reset: all counters 0, broken_o 0, any_broken_o 0, pending 0, report_valid_o 0, report_idx_o 0, report_count_o 0, FSM IDLE, rr pointer 0.
- Counter update per slot at each clk edge, with priority err_i over chk_i:
  - err_i=1: cnt = min(cnt+INCREMENT, 2^COUNT_BIT-1). Saturates; never wraps.
  - err_i=0 and chk_i=1: cnt = (cnt>=DECREMENT) ? cnt-DECREMENT : 0. Floors at 0.
  - otherwise cnt holds.
  - err_i=1 with chk_i=0 still counts as a mismatch.
- Broken detection: broken_o[i] sets at the same edge where the next counter value is >= BREAKING_THRESHOLD.
  - Latency: err_i at cycle t makes broken_o visible in cycle t+1.
  - Sticky until clear_i (see optional feature).
- Pending: a 0->1 transition of broken_o[i] sets pending[i] at the same edge.
- Report FSM:
  - IDLE: if any pending bit is set, select the first set bit searching from the rr pointer upward, wrapping at N_MOD-1 -> 0. Load report_idx_o and report_count_o, clear that pending bit, go to PRESENT. report_valid_o=1 from the next cycle.
  - PRESENT: report_valid_o=1; report_idx_o and report_count_o held stable. On report_valid_o & report_ready_i, set rr = idx+1 (mod N_MOD) and return to IDLE.
  - Back-to-back reports: at most one report per two cycles (IDLE cycle between reports).
- Simultaneous events:
  - Several slots breaking in the same cycle: all get pending; they are reported in round-robin order.
  - A slot breaking while the FSM is in PRESENT: stays pending until the current report is accepted.
- clear_i: highest priority. Zeros counters, broken_o, pending and rr, and forces the FSM to IDLE with report_valid_o=0, even mid-handshake. err_i in that same cycle is ignored.
- Asynchronous reset mid-handshake: returns immediately to reset values.

Optional Feature:
- Macro: FT_BRKMON_RECOVER_EN.
- Defined: broken_o[i] clears at the edge where slot i's counter decays to 0. A later re-break sets pending again and is re-reported.
- Undefined: broken_o is sticky until clear_i or rst_n; counter decay has no effect on broken_o.

Test Plan:
- Default parameters; err_i[2]=1 for 3 consecutive cycles -> counter2 = 1,2,3; broken_o=6'b000100 one cycle after the third strobe; report_valid_o=1 with report_idx_o=2, report_count_o=3; hold report_ready_i=0 for 5 cycles -> outputs stable; then ready=1 -> report_valid_o=0 next cycle.
- Alternate err_i[0] and chk_i[0]-only for 20 cycles -> counter0 toggles 1/0, never broken; 300 cycles of err_i[5]=1 -> counter5 saturates at 255, no wrap.
- err_i[1], err_i[4] and err_i[5] each held 3 cycles simultaneously with ready=1 -> reports idx 1, 4, 5 in that order, one IDLE cycle between them; a following break of slot 0 is reported after 5 (wrap).
- clear_i asserted while report_valid_o=1 for idx 3 -> next cycle report_valid_o=0, broken_o=0, all counters 0; err_i[3] asserted in the clear cycle is ignored.
- rst_n pulled low asynchronously mid-PRESENT -> all outputs 0 before the next clk edge.
- FT_BRKMON_RECOVER_EN defined: break slot 2 (counter 3), then 3 chk-only cycles -> broken_o[2] clears when counter reaches 0. Undefined: broken_o[2] remains 1.
